uart_image_loader: RTL

Byte-level protocol controller for the serial receive path: consumes the one-cycle byte strobes from the UART receiver and sequences image uploads into the frame buffer. Each packet starts with a sync byte, then a command byte. A load command streams exactly one full frame of pixel bytes into memory, with sequential write addresses. Any other command is forwarded to the processing pipeline as a one-cycle command strobe.

---
 rtl/uart_image_loader_if.sv | 26 ++
 rtl/uart_image_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_image_loader_if.sv
// Byte-stream and frame-buffer signal bundle for the UART image loader.
// The loader sits on the slave side; the UART receiver/frame buffer side is the master.
interface uart_image_loader_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            cmd_out;
    logic                  cmd_valid;
    logic                  busy;
    logic                  frame_done;
    logic                  timeout_err;

    modport master (
        output rx_data, rx_ready,
        input  mem_we, mem_addr, mem_wdata, cmd_out, cmd_valid, busy, frame_done, timeout_err
    );

    modport slave (
        input  rx_data, rx_ready,
        output mem_we, mem_addr, mem_wdata, cmd_out, cmd_valid, busy, frame_done, timeout_err
    );
endinterface

// File: rtl/uart_image_loader.sv
// Packet sequencer for the serial receive path: sync byte, command byte, then either
// a full frame of pixel writes (load command) or a one-cycle command strobe.
module uart_image_loader #(
    parameter int          IMG_WIDTH      = 160,
    parameter int          IMG_HEIGHT     = 120,
    parameter int          ADDR_WIDTH     = 15,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter logic [7:0]  CMD_LOAD       = 8'h01,
    parameter int          TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    uart_image_loader_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int N      = IMG_WIDTH * IMG_HEIGHT;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(N - 1);
    localparam logic [TW-1:0]         TMO_MAX  = TW'(TIMEOUT_CYCLES);
    // Expiry is flagged when the count would reach TIMEOUT_CYCLES, so the error
    // strobe lands TIMEOUT_CYCLES+1 clocks after the last byte strobe.
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_LOAD} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pix_q, pix_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       cmd_q, cmd_d;
    logic                    cv_q, cv_d;
    logic                    busy_q, busy_d;
    logic                    fd_q, fd_d;
    logic                    te_q, te_d;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] cnt);
        return (cnt == TMO_MAX) ? TMO_MAX : cnt + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        tmo_d   = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cmd_d   = cmd_q;
        cv_d    = 1'b0;
        fd_d    = 1'b0;
        te_d    = 1'b0;
        if (bus.rx_ready) begin
            case (state_q)
                S_IDLE: if (bus.rx_data == SYNC_BYTE) state_d = S_CMD;
                S_CMD: begin
                    if (bus.rx_data == CMD_LOAD) begin
                        state_d = S_LOAD;
                        pix_d   = '0;
                    end else begin
                        cmd_d   = bus.rx_data;
                        cv_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    we_d    = 1'b1;
                    addr_d  = pix_q;
                    wdata_d = bus.rx_data;
                    if (pix_q == LAST_PIX) begin
                        fd_d    = 1'b1;
                        pix_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                te_d    = 1'b1;
                pix_d   = '0;
                state_d = S_IDLE;
            end else begin
                tmo_d = sat_inc(tmo_q);
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cmd_q   <= '0;
            cv_q    <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cmd_q   <= cmd_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
            te_q    <= te_d;
        end
    end

    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.cmd_out     = cmd_q;
    assign bus.cmd_valid   = cv_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = fd_q;
    assign bus.timeout_err = te_q;
endmodule
